// File: rtl/skylark_pkg.sv
// Shared types and constants for the core's hazard control logic.
package skylark_pkg;

    // ALU operand source select driven into the EX-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Multi-cycle execute sequencer states.
    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

    // Architectural zero register; never a forwarding or hazard source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Returns 1 when a writing producer targets the given consumer source register.
    function automatic logic reg_match(input logic       we,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs);
        return we && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: holds the front of the pipe while a
// multi-cycle op sits in EX, and flags the final EX cycle of the op.
module mc_sequencer
    import skylark_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mc_op_E,
    output logic mcStall,
    output logic mc_busy,
    output logic mc_done
);

    // The first EX cycle is spent in IDLE, and the final one in BUSY with
    // the counter at zero, so the counter is loaded with MC_CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_CYCLES - 2);

    mc_state_t        state;
    logic [CNT_W-1:0] cnt;

    // State and counter update; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MC_IDLE;
            cnt     <= '0;
            mc_busy <= 1'b0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (mc_op_E) begin
                        state   <= MC_BUSY;
                        cnt     <= CNT_INIT;
                        mc_busy <= 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state   <= MC_IDLE;
                        mc_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= MC_IDLE;
                    cnt     <= '0;
                    mc_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stall decode: the op's first cycle is seen while still IDLE, so the
    // stall there must follow mc_op_E combinationally. Gated by reset so the
    // hold drops in the same cycle reset is asserted.
    always_comb begin
        mcStall = 1'b0;
        mc_done = 1'b0;
        if (!reset) begin
            if (state == MC_IDLE) begin
                mcStall = mc_op_E;
            end else begin
                mcStall = (cnt != '0);
                mc_done = (cnt == '0);
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller for the 5-stage core: operand forwarding,
// load-use detection, branch flushing and multi-cycle execute holds.
module hazard_ctrl
    import skylark_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic       RegWE_W_E,
    input  logic [4:0] rd_M,
    input  logic       RegWE_M,
    input  logic [4:0] rd_W,
    input  logic       RegWE_W,
    input  logic       PCSrcE,
    input  logic       mc_op_E,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       mc_busy,
    output logic       mc_done
);

    logic     mcStall;
    logic     lwStall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    mc_sequencer #(
        .MC_CYCLES (MC_CYCLES),
        .CNT_W     (CNT_W)
    ) u_mc_seq (
        .clk     (clk),
        .reset   (reset),
        .mc_op_E (mc_op_E),
        .mcStall (mcStall),
        .mc_busy (mc_busy),
        .mc_done (mc_done)
    );

    // Operand forwarding: the younger MEM result wins over WB; x0 never forwards.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (reg_match(RegWE_M, rd_M, rs1_E)) begin
            fwd_a = FWD_MEM;
        end else if (reg_match(RegWE_W, rd_W, rs1_E)) begin
            fwd_a = FWD_WB;
        end
        if (reg_match(RegWE_M, rd_M, rs2_E)) begin
            fwd_b = FWD_MEM;
        end else if (reg_match(RegWE_W, rd_W, rs2_E)) begin
            fwd_b = FWD_WB;
        end
    end

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // Load-use detection against the instruction currently in ID.
    always_comb begin
        lwStall = 1'b0;
        if (!reset) begin
            lwStall = reg_match(RegWE_W_E, rd_E, rs1_D) ||
                      reg_match(RegWE_W_E, rd_E, rs2_D);
        end
    end

    // Stall/flush combination. A multi-cycle hold suppresses the load-use
    // bubble (EX is frozen, so the check simply re-runs when the op leaves),
    // and a taken branch overrides any front-end hold.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (!reset) begin
            StallF = (lwStall || mcStall) && !PCSrcE;
            StallD = (lwStall || mcStall) && !PCSrcE;
            StallE = mcStall;
            FlushD = PCSrcE;
            FlushE = PCSrcE || (lwStall && !mcStall);
            FlushM = mcStall;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage core; drives StallF/StallD/StallE and FlushD/FlushE/FlushM into the IF/ID, ID/EX and EX/MEM pipeline registers.
- Produces ALU operand forwarding selects.
- Detects load-use hazards and taken branches/jumps.
- Sequences multi-cycle execute operations (threshold/accumulate extension) by holding the front of the pipe while the operation occupies E.

Parameters:
- MC_CYCLES, 4, total cycles a multi-cycle op occupies EX (legal 2..16).
- CNT_W, 4, width of the busy counter; must satisfy 2^CNT_W >= MC_CYCLES-1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rs1_D, rs2_D  in  5  source registers of the instruction in ID.
- rs1_E, rs2_E, rd_E  in  5  sources and destination of the instruction in EX.
- RegWE_W_E  in  1  EX instruction writes back from memory (load).
- rd_M  in  5  MEM destination.
- RegWE_M  in  1  MEM instruction writes the register file.
- rd_W  in  5  WB destination.
- RegWE_W  in  1  WB instruction writes the register file.
- PCSrcE  in  1  branch taken or jump in EX.
- mc_op_E  in  1  EX holds a multi-cycle op.
- StallF, StallD, StallE  out  1  stage hold.
- FlushD, FlushE, FlushM  out  1  bubble insert into the next register.
- ForwardAE, ForwardBE  out  2  operand select: 00 regfile, 01 WB result, 10 MEM result.
- mc_busy  out  1  FSM in BUSY.
- mc_done  out  1  final EX cycle of a multi-cycle op.

Behaviour:
- Reset (async): FSM to IDLE, cnt to 0. All stall/flush outputs, mc_busy and mc_done are 0. Forward selects are 00 when inputs are 0. Reset asserted mid multi-cycle op aborts the op; stalls drop in the same cycle.
- Forwarding is combinational, zero latency:
  - ForwardAE = 10 if RegWE_M && rd_M != 0 && rd_M == rs1_E.
  - Otherwise ForwardAE = 01 if RegWE_W && rd_W != 0 && rd_W == rs1_E.
  - Otherwise ForwardAE = 00.
  - ForwardBE is the same, using rs2_E.
  - MEM takes priority over WB when both match.
  - x0 is never forwarded.
- Load-use hazard: lwStall = RegWE_W_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D).
- Multi-cycle FSM with states IDLE and BUSY:
  - IDLE, mc_op_E=1: mcStall=1, go to BUSY, cnt <= MC_CYCLES-2.
  - BUSY, cnt != 0: mcStall=1, cnt decrements.
  - BUSY, cnt == 0: mcStall=0, mc_done=1, go to IDLE. The op advances to MEM at the next edge.
  - EX occupancy is exactly MC_CYCLES cycles.
  - A back-to-back multi-cycle op seen in IDLE on the following cycle starts normally.
  - mc_busy = (state == BUSY).
- Output equations:
  - StallF = StallD = (lwStall || mcStall) && !PCSrcE.
  - StallE = mcStall.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE || (lwStall && !mcStall).
  - FlushM = mcStall. A bubble enters MEM each held cycle.
- Simultaneous events:
  - mcStall dominates lwStall. The load-use check is re-evaluated once the op leaves EX, and no EX bubble is inserted while StallE is high.
  - PCSrcE with mcStall cannot occur (one EX slot). If it is presented anyway, flush wins and StallF/StallD stay 0.
- FlushE never coincides with StallE, so the ID/EX register's flush-over-stall priority is never exercised by this block.

Decomposition:
- skylark_pkg holds:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - mc_state_t enum (MC_IDLE, MC_BUSY).
  - REG_ZERO constant 5'd0.
- One sub-module, mc_sequencer: FSM plus counter with inputs mc_op_E, outputs mcStall, mc_busy, mc_done.
- hazard_ctrl instantiates mc_sequencer and keeps the forwarding and load-use logic inline.

Test Plan:
- Forwarding priority: rs1_E=5, rd_M=5, RegWE_M=1, rd_W=5, RegWE_W=1 -> ForwardAE=10. Drop RegWE_M -> 01. rd_M=rd_W=0 with rs1_E=0 -> 00.
- Load-use: RegWE_W_E=1, rd_E=7, rs2_D=7 -> StallF=StallD=1, FlushE=1, StallE=0 for one cycle. Next cycle rd_E=0 -> all 0.
- Branch: PCSrcE=1 with lwStall conditions also true -> FlushD=1, FlushE=1, StallF=StallD=0.
- Multi-cycle, MC_CYCLES=4: mc_op_E=1 at cycle 0 -> StallF/D/E=1 and FlushM=1 in cycles 0-2; cycle 3 stalls 0, mc_done=1; mc_busy=1 in cycles 1-3. Back-to-back op at cycle 4 repeats the pattern.
- Overlap: lwStall true during BUSY -> FlushE=0, StallE=1. After mc_done, lwStall alone -> FlushE=1.
- Reset mid-op: assert reset in cycle 1 of a 4-cycle op -> all outputs 0 immediately, mc_busy=0. After release with mc_op_E=0, the FSM stays IDLE.
